// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes, multi-cycle
// divide stalls, and interrupt entry. All outputs except state/counters are combinational.
module pipe_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_BITS   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          id_rs,
    input  logic [4:0]          id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic                ex_ld,
    input  logic [4:0]          ex_write,
    input  logic                ex_div,
    input  logic                ex_branch_taken,
    input  logic                irq_req,
    output logic                pc_en,
    output logic                if_id_en,
    output logic                id_ex_en,
    output logic                ex_mem_en,
    output logic                mem_wb_en,
    output logic                if_id_zero,
    output logic                id_ex_zero,
    output logic                ex_mem_zero,
    output logic                mem_wb_zero,
    output logic                pc_sel_exc,
    output logic                irq_ack,
    output logic                div_busy,
    output logic [CNT_BITS-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, DIV_WAIT, IRQ_ENTER} state_t;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t     state, state_next;
    logic [5:0] div_cnt, div_cnt_next;
    logic       load_use;

    assign load_use = ex_ld && (ex_write != 5'd0) &&
                      ((id_use_rs && (id_rs == ex_write)) ||
                       (id_use_rt && (id_rt == ex_write)));

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_zero   = 1'b0;
        id_ex_zero   = 1'b0;
        ex_mem_zero  = 1'b0;
        mem_wb_zero  = 1'b0;
        pc_sel_exc   = 1'b0;
        irq_ack      = 1'b0;
        div_busy     = 1'b0;
        state_next   = state;
        div_cnt_next = div_cnt;

        if (!rst_n) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
            {if_id_zero, id_ex_zero, ex_mem_zero, mem_wb_zero} = 4'b1111;
            state_next   = RUN;
            div_cnt_next = 6'd0;
        end else begin
            unique case (state)
                RUN: begin
                    if (irq_req) begin
                        pc_en      = 1'b0;
                        if_id_en   = 1'b0;
                        state_next = IRQ_ENTER;
                    end else if (ex_div) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_zero  = 1'b1;
                        state_next   = DIV_WAIT;
                        div_cnt_next = DIV_LOAD;
                    end else if (ex_branch_taken) begin
                        if_id_zero = 1'b1;
                        id_ex_zero = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        if_id_en   = 1'b0;
                        id_ex_zero = 1'b1;
                    end
                end
                DIV_WAIT: begin
                    // Counter zero is the release cycle: the divide leaves EX and fetch resumes.
                    if (div_cnt != 6'd0) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_zero  = 1'b1;
                        div_busy     = 1'b1;
                        div_cnt_next = div_cnt - 6'd1;
                    end else begin
                        state_next = RUN;
                    end
                end
                IRQ_ENTER: begin
                    if_id_zero  = 1'b1;
                    id_ex_zero  = 1'b1;
                    ex_mem_zero = 1'b1;
                    pc_sel_exc  = 1'b1;
                    irq_ack     = 1'b1;
                    state_next  = RUN;
                end
                default: state_next = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            div_cnt   <= 6'd0;
            stall_cnt <= '0;
        end else begin
            state   <= state_next;
            div_cnt <= div_cnt_next;
            if (!pc_en) stall_cnt <= stall_cnt + CNT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, flushes, divide wait, interrupts, counter wrap, reset.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_write;
    logic        id_use_rs, id_use_rt, ex_ld, ex_div, ex_branch_taken, irq_req;

    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_zero, id_ex_zero, ex_mem_zero, mem_wb_zero;
    logic        pc_sel_exc, irq_ack, div_busy;
    logic [15:0] stall_cnt;

    logic        s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
    logic        s_if_id_zero, s_id_ex_zero, s_ex_mem_zero, s_mem_wb_zero;
    logic        s_pc_sel_exc, s_irq_ack, s_div_busy;
    logic [3:0]  s_stall_cnt;

    int vectors    = 0;
    int miscompares = 0;
    int exp_stall  = 0;

    // {pc,if_id,id_ex,ex_mem,mem_wb en | if_id,id_ex,ex_mem,mem_wb zero | pc_sel_exc, irq_ack, div_busy}
    localparam logic [11:0] C_RUN  = 12'b11111_0000_000;
    localparam logic [11:0] C_LU   = 12'b00111_0100_000;
    localparam logic [11:0] C_BR   = 12'b11111_1100_000;
    localparam logic [11:0] C_DIVE = 12'b00011_0010_000;
    localparam logic [11:0] C_DIVW = 12'b00011_0010_001;
    localparam logic [11:0] C_IRQH = 12'b00111_0000_000;
    localparam logic [11:0] C_IRQE = 12'b11111_1110_110;
    localparam logic [11:0] C_RST  = 12'b00000_1111_000;

    pipe_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_ld(ex_ld), .ex_write(ex_write),
        .ex_div(ex_div), .ex_branch_taken(ex_branch_taken), .irq_req(irq_req),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_zero(if_id_zero), .id_ex_zero(id_ex_zero),
        .ex_mem_zero(ex_mem_zero), .mem_wb_zero(mem_wb_zero), .pc_sel_exc(pc_sel_exc),
        .irq_ack(irq_ack), .div_busy(div_busy), .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.DIV_CYCLES(32), .CNT_BITS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_ld(ex_ld), .ex_write(ex_write),
        .ex_div(ex_div), .ex_branch_taken(ex_branch_taken), .irq_req(irq_req),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en),
        .mem_wb_en(s_mem_wb_en), .if_id_zero(s_if_id_zero), .id_ex_zero(s_id_ex_zero),
        .ex_mem_zero(s_ex_mem_zero), .mem_wb_zero(s_mem_wb_zero), .pc_sel_exc(s_pc_sel_exc),
        .irq_ack(s_irq_ack), .div_busy(s_div_busy), .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_ctl(input string tag, input logic [11:0] expected);
        check(tag, 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                        if_id_zero, id_ex_zero, ex_mem_zero, mem_wb_zero,
                        pc_sel_exc, irq_ack, div_busy}), 32'(expected));
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_cnt16"}, 32'(stall_cnt), 32'(exp_stall[15:0]));
        check({tag, "_cnt4"}, 32'(s_stall_cnt), 32'(exp_stall[3:0]));
    endtask

    // Advance one clock; the expected stall count follows what this cycle should have done.
    task automatic tick(input bit stalled);
        @(posedge clk);
        if (!rst_n) exp_stall = 0;
        else if (stalled) exp_stall++;
        #1;
    endtask

    task automatic idle_inputs;
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_ld = 1'b0; ex_write = 5'd0; ex_div = 1'b0; ex_branch_taken = 1'b0; irq_req = 1'b0;
    endtask

    task automatic set_load_use;
        ex_ld = 1'b1; ex_write = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #1 check_ctl("reset_outputs", C_RST);
        tick(0);
        check_cnt("reset_count");
        tick(0);

        rst_n = 1'b1;
        #1 check_ctl("run_idle", C_RUN);
        tick(0);
        check_cnt("run_idle");

        set_load_use();
        #1 check_ctl("load_use_rs", C_LU);
        tick(1);
        check_cnt("load_use_rs");
        idle_inputs();
        #1 check_ctl("after_bubble", C_RUN);
        tick(0);

        set_load_use(); ex_write = 5'd0; id_rs = 5'd0;
        #1 check_ctl("load_use_r0", C_RUN);
        tick(0);
        check_cnt("load_use_r0");

        idle_inputs(); ex_ld = 1'b1; ex_write = 5'd17; id_rt = 5'd17; id_use_rt = 1'b1;
        #1 check_ctl("load_use_rt", C_LU);
        tick(1);
        idle_inputs(); ex_ld = 1'b1; ex_write = 5'd17; id_rs = 5'd17; id_use_rs = 1'b0;
        #1 check_ctl("rs_unused", C_RUN);
        tick(0);

        idle_inputs(); set_load_use(); ex_branch_taken = 1'b1;
        #1 check_ctl("branch_over_lu", C_BR);
        tick(0);
        check_cnt("branch_over_lu");

        idle_inputs(); irq_req = 1'b1; ex_branch_taken = 1'b1;
        #1 check_ctl("irq_hold", C_IRQH);
        tick(1);
        irq_req = 1'b0; ex_branch_taken = 1'b0;
        #1 check_ctl("irq_enter", C_IRQE);
        tick(0);
        #1 check_ctl("irq_back_run", C_RUN);
        check_cnt("irq");
        tick(0);

        ex_div = 1'b1;
        #1 check_ctl("div_entry", C_DIVE);
        tick(1);
        ex_div = 1'b0;
        for (int i = 0; i < 31; i++) begin
            #1 check_ctl("div_wait", C_DIVW);
            tick(1);
        end
        #1 check_ctl("div_release", C_RUN);
        tick(0);
        #1 check_ctl("div_after", C_RUN);
        check_cnt("div32");
        tick(0);

        ex_div = 1'b1;
        #1 check_ctl("div2_entry", C_DIVE);
        tick(1);
        ex_div = 1'b0;
        for (int i = 0; i < 31; i++) begin
            if (i == 10) irq_req = 1'b1;
            #1 check_ctl("div2_wait_irq", C_DIVW);
            tick(1);
        end
        #1 check_ctl("div2_release", C_RUN);
        tick(0);
        #1 check_ctl("irq_after_div_hold", C_IRQH);
        tick(1);
        #1 check_ctl("irq_after_div_ack", C_IRQE);
        tick(0);
        #1 check_ctl("irq_held_rehold", C_IRQH);
        tick(1);
        #1 check_ctl("irq_held_reack", C_IRQE);
        tick(0);
        irq_req = 1'b0;
        #1 check_ctl("irq_done", C_RUN);
        check_cnt("div2_irq");
        tick(0);

        for (int i = 0; i < 16; i++) begin
            set_load_use();
            #1 check_ctl("wrap_lu", C_LU);
            tick(1);
            check_cnt("wrap_step");
            idle_inputs();
            tick(0);
        end
        check("wrap_cnt4_mid", 32'(s_stall_cnt), 32'(exp_stall % 16));

        set_load_use();
        tick(1);
        set_load_use();
        tick(1);
        idle_inputs();
        rst_n = 1'b0;
        #1 check_ctl("reset_mid_count", C_RST);
        tick(0);
        check_cnt("reset_mid_count");
        rst_n = 1'b1;
        tick(0);

        ex_div = 1'b1;
        tick(1);
        ex_div = 1'b0;
        tick(1);
        tick(1);
        rst_n = 1'b0;
        #1 check_ctl("reset_in_div", C_RST);
        tick(0);
        rst_n = 1'b1;
        #1 check_ctl("run_after_div_reset", C_RUN);
        check_cnt("div_reset");
        tick(0);

        irq_req = 1'b1;
        tick(1);
        irq_req = 1'b0;
        rst_n = 1'b0;
        #1 check_ctl("reset_in_irq_enter", C_RST);
        tick(0);
        rst_n = 1'b1;
        #1 check_ctl("run_after_irq_reset", C_RUN);
        tick(0);
        #1 check_ctl("no_late_ack", C_RUN);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter DIV_CYCLES, default 32, busy cycles of the multi-cycle divider (range 2..63).
REQ-002 Parameter CNT_BITS, default 16, width of the stall-cycle counter.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-006 id_use_rs, id_use_rt  input  1 each  ID instruction reads rs / rt.
REQ-007 ex_ld  input  1  EX instruction is a load.
REQ-008 ex_write  input  5  destination register of the EX instruction.
REQ-009 ex_div  input  1  EX holds a divide; qualified only in RUN.
REQ-010 ex_branch_taken  input  1  branch/jump in EX resolved taken.
REQ-011 irq_req  input  1  level interrupt request.
REQ-012 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  load enables for PC and pipeline registers (drive the registers' "stall" port; 1 = load).
REQ-013 if_id_zero, id_ex_zero, ex_mem_zero, mem_wb_zero  output  1 each  synchronous clear (drive "zero" ports).
REQ-014 pc_sel_exc  output  1  PC loads exception vector this cycle.
REQ-015 irq_ack  output  1  one-cycle acknowledge of interrupt entry.
REQ-016 div_busy  output  1  divider wait in progress.
REQ-017 stall_cnt  output  CNT_BITS  count of cycles with pc_en = 0.

Function
REQ-018 States: RUN, DIV_WAIT, IRQ_ENTER; state, divide counter and stall_cnt are registered, all other outputs combinational from state and inputs.
REQ-019 Load-use hazard (RUN): ex_ld = 1, ex_write != 0, and (id_use_rs and id_rs == ex_write, or id_use_rt and id_rt == ex_write).
REQ-020 Priority within RUN: irq_req > ex_div > ex_branch_taken > load-use.
REQ-021 RUN, no event: all *_en = 1, all *_zero = 0, pc_sel_exc = 0.
REQ-022 RUN, load-use only: pc_en = if_id_en = 0, id_ex_zero = 1, other enables 1; exactly one bubble per hazard.
REQ-023 RUN, ex_branch_taken (no irq/div): if_id_zero = id_ex_zero = 1, all enables 1; load-use ignored that cycle.
REQ-024 RUN, ex_div (no irq): enter DIV_WAIT, counter loaded with DIV_CYCLES-1; this cycle pc_en = if_id_en = id_ex_en = 0, ex_mem_zero = 1.
REQ-025 DIV_WAIT: pc_en = if_id_en = id_ex_en = 0, ex_mem_zero = 1, mem_wb_en = 1, div_busy = 1; counter decrements each cycle; at counter == 0 return to RUN with id_ex_en = 1 that cycle so the divide advances; total stall = DIV_CYCLES cycles.
REQ-026 irq_req ignored in DIV_WAIT; if still high on return to RUN, taken in RUN next cycle.
REQ-027 RUN, irq_req: enter IRQ_ENTER; this cycle pc_en = if_id_en = 0 (hold).
REQ-028 IRQ_ENTER (one cycle): if_id_zero = id_ex_zero = ex_mem_zero = 1, pc_en = 1, pc_sel_exc = 1, irq_ack = 1, mem_wb_en = 1; then RUN unconditionally.
REQ-029 irq_ack asserts once per IRQ_ENTER; held irq_req re-enters only after one RUN cycle.
REQ-030 mem_wb_zero is 0 outside reset; mem_wb_en is 1 in every state.
REQ-031 stall_cnt increments by 1 in every cycle with pc_en = 0, wraps from all-ones to 0.

Reset
REQ-032 rst_n = 0 at posedge: state = RUN, counter = 0, stall_cnt = 0.
REQ-033 While rst_n = 0: all *_zero = 1, all *_en = 0, pc_sel_exc = irq_ack = div_busy = 0.
REQ-034 Reset mid DIV_WAIT or IRQ_ENTER aborts to RUN; no irq_ack issued.

Verification
REQ-035 ex_ld=1, ex_write=8, id_rs=8, id_use_rs=1 for one cycle -> pc_en=if_id_en=0, id_ex_zero=1 that cycle, stall_cnt 0->1.
REQ-036 Same with ex_write=0 -> no stall, all enables 1.
REQ-037 ex_div pulse, DIV_CYCLES=32 -> div_busy high 31 cycles after entry, pc_en low 32 consecutive cycles, stall_cnt +32.
REQ-038 irq_req and ex_branch_taken same cycle -> hold cycle, then IRQ_ENTER with pc_sel_exc=irq_ack=1 and three zeros; branch flush not applied.
REQ-039 irq_req rises during DIV_WAIT -> no ack until DIV_WAIT exits; irq_ack exactly two cycles after exit.
REQ-040 CNT_BITS=4, 16 load-use stalls -> stall_cnt wraps 15->0; rst_n=0 mid-count -> stall_cnt=0 next edge.
